traceback_unit: RTL and testbench

TRACEBACK_UNIT -- requirements
Module: traceback_unit

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/min_state_select.sv | 33 +++
 rtl/traceback_unit.sv | 151 +++++++++++++++
 tb/tb_traceback_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi traceback types: trellis state, FSM encoding and metric width default.
package viterbi_pkg;

  localparam int unsigned NUM_STATES   = 4;
  localparam int unsigned PM_W_DEFAULT = 2;

  typedef logic [1:0] state_t;

  typedef enum logic [1:0] {
    StFill,
    StTrace,
    StOut
  } tb_state_t;

  // Predecessor on the survivor path: the decision bit picks the odd or even old state.
  function automatic state_t prev_state(input state_t cur, input logic dec);
    return {cur[0], dec};
  endfunction

endpackage

// File: rtl/min_state_select.sv
// Combinational argmin over four path metrics; ties go to the lowest state index.
module min_state_select
  import viterbi_pkg::*;
#(
  parameter int unsigned PM_W = PM_W_DEFAULT
) (
  input  logic [PM_W-1:0] pm_0,
  input  logic [PM_W-1:0] pm_1,
  input  logic [PM_W-1:0] pm_2,
  input  logic [PM_W-1:0] pm_3,
  output state_t          min_state
);

  logic [PM_W-1:0] best;

  // Strict less-than keeps the earlier index on equal metrics.
  always_comb begin
    min_state = state_t'(0);
    best      = pm_0;
    if (pm_1 < best) begin
      best      = pm_1;
      min_state = state_t'(1);
    end
    if (pm_2 < best) begin
      best      = pm_2;
      min_state = state_t'(2);
    end
    if (pm_3 < best) begin
      min_state = state_t'(3);
    end
  end

endmodule

// File: rtl/traceback_unit.sv
// Frame-based Viterbi traceback: collect FRAME_LEN decision vectors, trace back, emit bits.
// Define TB_ZERO_TERM_EN to start traceback from state 0 instead of the minimum-metric state.
module traceback_unit
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned PM_W      = PM_W_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_dec,
  input  logic [PM_W-1:0] i_PM_0,
  input  logic [PM_W-1:0] i_PM_1,
  input  logic [PM_W-1:0] i_PM_2,
  input  logic [PM_W-1:0] i_PM_3,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_bit,
  output logic            o_last
);

  localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_LEN - 1);

  tb_state_t       state_q, state_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0] idx_q, idx_d;
  state_t          cur_q, cur_d;
  logic            ready_en_q;

  logic [3:0]           mem_q [FRAME_LEN];
  logic [FRAME_LEN-1:0] bits_q;
  logic [3:0]           dec_rd;
  logic                 accept;
  logic                 bit_we;
  state_t               start_state;

`ifdef TB_ZERO_TERM_EN
  logic unused_pm;
  assign unused_pm   = ^{i_PM_0, i_PM_1, i_PM_2, i_PM_3};
  assign start_state = state_t'(0);
`else
  min_state_select #(
    .PM_W (PM_W)
  ) u_min_state_select (
    .pm_0      (i_PM_0),
    .pm_1      (i_PM_1),
    .pm_2      (i_PM_2),
    .pm_3      (i_PM_3),
    .min_state (start_state)
  );
`endif

  // Held low through reset so o_ready only rises on the first edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  assign o_ready = ready_en_q && (state_q == StFill);
  assign dec_rd  = mem_q[idx_q];

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    accept   = 1'b0;
    bit_we   = 1'b0;
    unique case (state_q)
      StFill: begin
        if (i_valid && o_ready) begin
          accept = 1'b1;
          if (wr_cnt_q == LastIdx) begin
            wr_cnt_d = '0;
            cur_d    = start_state;
            idx_d    = LastIdx;
            state_d  = StTrace;
          end else begin
            wr_cnt_d = wr_cnt_q + CntW'(1);
          end
        end
      end
      StTrace: begin
        bit_we = 1'b1;
        cur_d  = prev_state(cur_q, dec_rd[cur_q]);
        if (idx_q == '0) begin
          state_d = StOut;
        end else begin
          idx_d = idx_q - CntW'(1);
        end
      end
      StOut: begin
        if (i_ready) begin
          if (rd_cnt_q == LastIdx) begin
            rd_cnt_d = '0;
            state_d  = StFill;
          end else begin
            rd_cnt_d = rd_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StFill;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      idx_q    <= '0;
      cur_q    <= state_t'(0);
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      idx_q    <= idx_d;
      cur_q    <= cur_d;
    end
  end

  // Survivor memory and bit buffer are always rewritten before being read, so no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem_q[wr_cnt_q] <= i_dec;
    end
    if (bit_we) begin
      bits_q[idx_q] <= cur_q[1];
    end
  end

  always_comb begin
    o_valid = 1'b0;
    o_bit   = 1'b0;
    o_last  = 1'b0;
    if (state_q == StOut) begin
      o_valid = 1'b1;
      o_bit   = bits_q[rd_cnt_q];
      o_last  = (rd_cnt_q == LastIdx);
    end
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Randomized self-checking bench for traceback_unit against a frame-level traceback model.
module tb_traceback_unit;
  import viterbi_pkg::*;

  localparam int unsigned L  = 4;
  localparam int unsigned PW = PM_W_DEFAULT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [3:0]    i_dec = '0;
  logic [PW-1:0] pm0 = '0, pm1 = '0, pm2 = '0, pm3 = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic          o_bit;
  logic          o_last;

  int checks = 0;
  int failures = 0;

  traceback_unit #(
    .FRAME_LEN (L),
    .PM_W      (PW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_dec   (i_dec),
    .i_PM_0  (pm0),
    .i_PM_1  (pm1),
    .i_PM_2  (pm2),
    .i_PM_3  (pm3),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_bit   (o_bit),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Start state: zero-terminated, or first index holding the smallest final metric.
  function automatic int model_start(input int p [4]);
`ifdef TB_ZERO_TERM_EN
    return 0;
`else
    int best = 0;
    for (int s = 1; s < 4; s++) if (p[s] < p[best]) best = s;
    return best;
`endif
  endfunction

  // Walk backwards: emit the MSB of the state, then hop to the recorded predecessor.
  function automatic logic [L-1:0] model_bits(input logic [4*L-1:0] decs, input int start);
    int s = start;
    logic [L-1:0] b = '0;
    for (int k = L - 1; k >= 0; k--) begin
      b[k] = (s / 2) % 2 == 1;
      s = (s % 2) * 2 + (decs[4*k + s] ? 1 : 0);
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] rand_pm();
    logic [31:0] r = $urandom;
    return r[PW-1:0];
  endfunction

  function automatic logic [3:0] rand_dec();
    logic [31:0] r = $urandom;
    return r[3:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_ready", o_ready, 0);
    check_eq("rst_bit", o_bit, 0);
    check_eq("rst_last", o_last, 0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("ready_pre_edge", o_ready, 0);
    @(posedge clk);
    #1;
    check_eq("ready_post_rst", o_ready, 1);
  endtask

  // Present n symbols; non-final PMs are random so only the final ones may matter.
  task automatic drive_syms(input logic [4*L-1:0] decs, input int p [4], input int n);
    for (int i = 0; i < n; i++) begin
      check_eq("ready_fill", o_ready, 1);
      i_valid = 1'b1;
      i_dec = decs[4*i +: 4];
      if (i == L - 1) begin
        pm0 = PW'(p[0]); pm1 = PW'(p[1]); pm2 = PW'(p[2]); pm3 = PW'(p[3]);
      end else begin
        pm0 = rand_pm(); pm1 = rand_pm(); pm2 = rand_pm(); pm3 = rand_pm();
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
  endtask

  // Count cycles to first o_valid while poking junk inputs that must be ignored.
  task automatic wait_trace();
    int cnt = 1;
    while (!o_valid && cnt <= int'(L) + 6) begin
      check_eq("ready_trace", o_ready, 0);
      i_valid = $urandom_range(0, 1) == 1;
      i_dec = rand_dec();
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq("latency", cnt, L + 1);
  endtask

  task automatic receive(input logic [L-1:0] exp, input int mode, output logic [L-1:0] got);
    int r = 0;
    int guard = 0;
    int stalls = 0;
    logic rdy;
    got = '0;
    while (r < int'(L) && guard < 200) begin
      check_eq("out_valid", o_valid, 1);
      check_eq("out_bit", o_bit, exp[r]);
      check_eq("out_last", o_last, (r == int'(L) - 1) ? 1 : 0);
      check_eq("ready_out", o_ready, 0);
      got[r] = o_bit;
      if (mode == 1) begin
        rdy = !(r == 1 && stalls < 3);
        if (!rdy) stalls++;
      end else if (mode == 2) begin
        rdy = $urandom_range(0, 2) != 0;
      end else begin
        rdy = 1'b1;
      end
      i_ready = rdy;
      i_valid = (rdy && r == int'(L) - 1) ? 1'b0 : ($urandom_range(0, 1) == 1);
      i_dec = rand_dec();
      @(posedge clk);
      #1;
      if (rdy) r++;
      guard++;
    end
    i_ready = 1'b0;
    i_valid = 1'b0;
    check_eq("handshakes", r, L);
    check_eq("valid_after", o_valid, 0);
    check_eq("ready_back", o_ready, 1);
  endtask

  task automatic run_frame(input logic [4*L-1:0] decs, input int p [4], input int mode,
                           output logic [L-1:0] got);
    logic [L-1:0] exp = model_bits(decs, model_start(p));
    drive_syms(decs, p, L);
    wait_trace();
    receive(exp, mode, got);
  endtask

  task automatic rand_frame(input int mode);
    logic [4*L-1:0] decs;
    int p [4];
    logic [L-1:0] got;
    for (int i = 0; i < int'(L); i++) decs[4*i +: 4] = rand_dec();
    for (int s = 0; s < 4; s++) p[s] = int'(rand_pm());
    run_frame(decs, p, mode, got);
  endtask

  initial begin
    logic [L-1:0] got;
    logic [4*L-1:0] zeros = '0;
    logic [4*L-1:0] decs;
    int p [4];

    do_reset();

    p = '{0, 1, 2, 3};
    run_frame(zeros, p, 0, got);
    check_eq("asc_pm_bits", got, 0);

    p = '{3, 3, 3, 0};
    run_frame(zeros, p, 0, got);
`ifdef TB_ZERO_TERM_EN
    check_eq("min3_bits", got, 0);
`else
    check_eq("min3_bits", got, 4'b1100);
`endif

    p = '{2, 2, 2, 2};
    run_frame(zeros, p, 0, got);
    check_eq("tie_bits", got, 0);

    rand_frame(1);

    // Partial frame discarded by reset.
    for (int i = 0; i < int'(L); i++) decs[4*i +: 4] = rand_dec();
    p = '{1, 0, 2, 3};
    drive_syms(decs, p, 2);
    do_reset();
    rand_frame(0);

    // Reset mid-TRACE.
    drive_syms(decs, p, L);
    @(posedge clk);
    #1;
    do_reset();
    rand_frame(2);

    // Reset mid-OUT.
    drive_syms(decs, p, L);
    wait_trace();
    check_eq("out_before_rst", o_valid, 1);
    do_reset();
    rand_frame(2);

    for (int n = 0; n < 25; n++) rand_frame(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
